// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver: time-multiplexed 8-digit seven-segment driver.
// Each digit slot starts with GUARD_CYC anode-off cycles and then shows the digit.
// Digit codes and dp are snapshotted once per frame, so every frame is coherent.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blanks leading zero digits).
module sevenseg_scan_driver #(
   parameter int SIMULATE  = 0,
   parameter int GUARD_CYC = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] d0,
   input  logic [4:0] d1,
   input  logic [4:0] d2,
   input  logic [4:0] d3,
   input  logic [4:0] d4,
   input  logic [4:0] d5,
   input  logic [4:0] d6,
   input  logic [4:0] d7,
   input  logic [7:0] dp,
   output logic [7:0] an,
   output logic [6:0] seg,
   output logic       dp_n,
   output logic       frame_tick
);

   localparam int SLOT_CNT = (SIMULATE != 0) ? 7 : 12_499;
   localparam int CW       = $clog2(SLOT_CNT + 1);
   localparam logic [CW-1:0] SLOT_MAX = CW'(SLOT_CNT);
   localparam logic [CW-1:0] GUARD_C  = CW'(GUARD_CYC);

   typedef enum logic {ST_GUARD = 1'b0, ST_SHOW = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0][4:0] snap_q;
   logic [7:0]      dps_q;
   logic [7:0]      an_q, an_d;
   logic [6:0]      seg_q, seg_d;
   logic            dpn_q, dpn_d;
   logic            ft_q, ft_d;
   logic            wrap_s;
   logic            capture_s;
   logic [7:0]      sup_s;
   logic [4:0]      code_s;

   // Hex glyphs, single-segment codes and blank codes, active-low g..a.
   function automatic logic [6:0] decode(input logic [4:0] code);
      logic [6:0] s;
      case (code)
         5'd0:    s = 7'b1000000;
         5'd1:    s = 7'b1111001;
         5'd2:    s = 7'b0100100;
         5'd3:    s = 7'b0110000;
         5'd4:    s = 7'b0011001;
         5'd5:    s = 7'b0010010;
         5'd6:    s = 7'b0000010;
         5'd7:    s = 7'b1111000;
         5'd8:    s = 7'b0000000;
         5'd9:    s = 7'b0010000;
         5'd10:   s = 7'b0001000;
         5'd11:   s = 7'b0000011;
         5'd12:   s = 7'b1000110;
         5'd13:   s = 7'b0100001;
         5'd14:   s = 7'b0000110;
         5'd15:   s = 7'b0001110;
         5'd16:   s = 7'b1111110;
         5'd17:   s = 7'b1111101;
         5'd18:   s = 7'b1111011;
         5'd19:   s = 7'b1110111;
         5'd20:   s = 7'b1101111;
         5'd21:   s = 7'b1011111;
         5'd22:   s = 7'b0111111;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   assign wrap_s    = (cnt_q == SLOT_MAX);
   assign capture_s = (cnt_q == {CW{1'b0}}) && (idx_q == 3'd0);
   assign code_s    = snap_q[idx_q];

`ifdef LEADING_ZERO_BLANK_EN
   logic above_ok_s;

   // Mark zero digits whose higher digits are all zero or blank; digit 0 always shows.
   always_comb begin
      sup_s      = 8'h00;
      above_ok_s = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         if ((i != 0) && above_ok_s && (snap_q[i] == 5'd0)) begin
            sup_s[i] = 1'b1;
         end else begin
            sup_s[i] = 1'b0;
         end
         above_ok_s = above_ok_s && ((snap_q[i] == 5'd0) || (snap_q[i] >= 5'd23));
      end
   end
`else
   assign sup_s = 8'h00;
`endif

   // Slot counter, digit index and GUARD/SHOW next-state logic.
   always_comb begin
      cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
      idx_d   = idx_q;
      state_d = state_q;
      if (wrap_s) begin
         cnt_d = {CW{1'b0}};
         idx_d = idx_q + 3'd1;
      end else begin
         idx_d = idx_q;
      end
      case (state_q)
         ST_GUARD: begin
            if (!wrap_s && (cnt_d == GUARD_C)) begin
               state_d = ST_SHOW;
            end else begin
               state_d = ST_GUARD;
            end
         end
         ST_SHOW: begin
            if (wrap_s) begin
               state_d = ST_GUARD;
            end else begin
               state_d = ST_SHOW;
            end
         end
         default: state_d = ST_GUARD;
      endcase
   end

   // Output values for the next cycle, derived from the current slot state.
   always_comb begin
      an_d  = 8'hFF;
      seg_d = 7'h7F;
      dpn_d = 1'b1;
      ft_d  = capture_s;
      if (state_q == ST_SHOW) begin
         an_d  = ~(8'd1 << idx_q);
         dpn_d = ~dps_q[idx_q];
         if (sup_s[idx_q]) begin
            seg_d = 7'h7F;
         end else begin
            seg_d = decode(code_s);
         end
      end else begin
         an_d  = 8'hFF;
         seg_d = 7'h7F;
         dpn_d = 1'b1;
      end
   end

   // State, counter, snapshot and registered outputs; reset clears everything at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_GUARD;
         cnt_q   <= {CW{1'b0}};
         idx_q   <= 3'd0;
         snap_q  <= {8{5'd31}};
         dps_q   <= 8'h00;
         an_q    <= 8'hFF;
         seg_q   <= 7'h7F;
         dpn_q   <= 1'b1;
         ft_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         if (capture_s) begin
            snap_q <= {d7, d6, d5, d4, d3, d2, d1, d0};
            dps_q  <= dp;
         end else begin
            snap_q <= snap_q;
            dps_q  <= dps_q;
         end
         an_q  <= an_d;
         seg_q <= seg_d;
         dpn_q <= dpn_d;
         ft_q  <= ft_d;
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign dp_n       = dpn_q;
   assign frame_tick = ft_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Bench for sevenseg_scan_driver (SIMULATE=1, GUARD_CYC=2): directed frames plus
// randomized inputs, compared every cycle to a frame/slot arithmetic reference.
module tb_sevenseg_scan_driver;

   localparam int G     = 2;
   localparam int SLOT  = 8;
   localparam int FRAME = 64;

   localparam logic [6:0] HEX [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] d [8];
   logic [7:0] dp;
   logic [7:0] an;
   logic [6:0] seg;
   logic       dp_n;
   logic       frame_tick;

   int n_cmp = 0;
   int n_err = 0;
   int n     = 0;
   int m_snap [8];
   logic [7:0] m_dp;

   sevenseg_scan_driver #(.SIMULATE(1), .GUARD_CYC(G)) dut (
      .clk(clk), .reset(reset),
      .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
      .d4(d[4]), .d5(d[5]), .d6(d[6]), .d7(d[7]),
      .dp(dp), .an(an), .seg(seg), .dp_n(dp_n), .frame_tick(frame_tick));

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [6:0] m_glyph(input int i);
      int c;
      bit blank;
      c = m_snap[i];
      blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      if (c == 0 && i > 0) begin
         blank = 1'b1;
         for (int j = i + 1; j < 8; j++)
            if (!(m_snap[j] == 0 || m_snap[j] >= 23)) blank = 1'b0;
      end
`endif
      if (blank) return 7'h7F;
      if (c < 16) return HEX[c];
      if (c <= 22) return 7'h7F & ~(7'd1 << (c - 16));
      return 7'h7F;
   endfunction

   // One clock: predict outputs from edge count n, then compare shortly after the edge.
   task automatic step();
      int cnt, idx;
      logic [7:0] ea;
      logic [6:0] es;
      logic ed, ef;
      @(posedge clk);
      cnt = n % SLOT;
      idx = (n / SLOT) % 8;
      if (cnt >= G) begin
         ea = 8'hFF ^ (8'd1 << idx);
         es = m_glyph(idx);
         ed = ~m_dp[idx];
      end else begin
         ea = 8'hFF;
         es = 7'h7F;
         ed = 1'b1;
      end
      ef = ((n % FRAME) == 0);
      if ((n % FRAME) == 0) begin
         for (int i = 0; i < 8; i++) m_snap[i] = d[i];
         m_dp = dp;
      end
      n++;
      #1;
      chk("an", an, ea);
      chk("seg", seg, es);
      chk("dp_n", dp_n, ed);
      chk("frame_tick", frame_tick, ef);
   endtask

   task automatic rand_inputs();
      for (int i = 0; i < 8; i++)
         d[i] = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      dp = 8'($urandom);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_an"}, an, 8'hFF);
      chk({tag, "_seg"}, seg, 7'h7F);
      chk({tag, "_dp_n"}, dp_n, 1'b1);
      chk({tag, "_ft"}, frame_tick, 1'b0);
   endtask

   initial begin
      int k;
      reset = 1'b1;
      for (int i = 0; i < 8; i++) d[i] = 5'd31;
      dp = 8'h00;
      for (int i = 0; i < 8; i++) m_snap[i] = 31;
      m_dp = 8'h00;
      #2 reset = 1'b0;
      #1 chk_reset_outputs("rst_async");
      @(posedge clk); #1 chk_reset_outputs("rst_hold");

      // Directed frame: hex, single-segment and blank codes with dp on digit 0.
      d[0] = 5'd5; d[1] = 5'd16; d[2] = 5'd22; d[3] = 5'd25;
      dp = 8'h01;
      #2 reset = 1'b1;
      n = 0;
      for (k = 0; k < FRAME; k++) begin
         step();
         if (k == 0)  chk("lit_ft0", frame_tick, 1'b1);
         if (k == 1)  chk("lit_guard_an", an, 8'hFF);
         if (k == 4)  begin chk("lit_d0_seg", seg, 7'b0010010); chk("lit_d0_dp", dp_n, 1'b0); end
         if (k == 12) chk("lit_d1_seg", seg, 7'b1111110);
         if (k == 20) chk("lit_d2_seg", seg, 7'b0111111);
         if (k == 28) begin chk("lit_d3_seg", seg, 7'h7F); chk("lit_d3_dp", dp_n, 1'b1); end
         if (k == 60) chk("lit_d7_an", an, 8'h7F);
      end

      // Mid-frame input change must wait for the next frame.
      d[0] = 5'd3;
      for (k = FRAME; k < 3 * FRAME; k++) begin
         if (k == FRAME + 4 * SLOT) d[0] = 5'd8;
         step();
         if (k == FRAME + 4)     chk("lit_hold_3", seg, 7'b0110000);
         if (k == 2 * FRAME + 4) chk("lit_new_8", seg, 7'b0000000);
      end

      // Leading-zero pattern d7..d0 = 0,0,0,0,0,1,0,0.
      for (int i = 0; i < 8; i++) d[i] = 5'd0;
      d[2] = 5'd1;
      dp = 8'h00;
      for (k = 0; k < FRAME; k++) begin
         step();
`ifdef LEADING_ZERO_BLANK_EN
         if (k == 60) chk("lit_lzb_d7", seg, 7'h7F);
`else
         if (k == 60) chk("lit_lzb_d7", seg, 7'b1000000);
`endif
         if (k == 20) chk("lit_lzb_d2", seg, 7'b1111001);
         if (k == 4)  chk("lit_lzb_d0", seg, 7'b1000000);
      end

      // Randomized inputs changing on every cycle.
      for (k = 0; k < 10 * FRAME; k++) begin
         step();
         rand_inputs();
      end

      // Reset in the SHOW phase of slot 5.
      while ((n % FRAME) != 5 * SLOT + 4) step();
      chk("pre_rst_an", an, 8'hDF);
      #2 reset = 1'b0;
      #1 chk_reset_outputs("rst_mid");
      @(posedge clk); #1 chk_reset_outputs("rst_mid_hold");
      rand_inputs();
      for (int i = 0; i < 8; i++) m_snap[i] = 31;
      m_dp = 8'h00;
      #2 reset = 1'b1;
      n = 0;
      for (k = 0; k < 2 * FRAME; k++) begin
         step();
         if (k == 0) chk("lit_ft_after_rst", frame_tick, 1'b1);
         if (k == 1) chk("lit_ft_drop", frame_tick, 1'b0);
         if ((k % 7) == 3) rand_inputs();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
